// File: rtl/sreg_rx.sv
// sreg_rx: serial-to-parallel receiver for 2-bit symbols, LSB symbol first.
// A word is NSYM = WORD_W/2 symbols and starts on a symbol flagged with
// frame_start. Completed words go into a single-entry output register that
// uses a valid/ready handshake.
// Optional build macro SREG_RX_PARITY_EN: each word is followed by one
// parity symbol (odd parity carried in sin_data[0]), and the result is
// reported on perr.
// Ports:
//   sclk, rst_n      clock, synchronous active-low reset
//   sin_valid        sin_data/frame_start are meaningful this cycle
//   sin_data[1:0]    incoming symbol
//   frame_start      first symbol of a word
//   out_valid        data_out holds a word (registered)
//   out_ready        consumer takes the word when out_valid && out_ready
//   data_out         assembled word (registered)
//   perr             parity error for data_out (registered; 0 without parity)
//   overrun          sticky: a completed word was dropped
//   frag_err         sticky: a partial word was cut short by frame_start
//   err_clr          clears overrun and frag_err
//   busy             a word is in progress (registered)
module sreg_rx #(
  parameter int unsigned WORD_W = 42
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              sin_valid,
  input  logic [1:0]        sin_data,
  input  logic              frame_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] data_out,
  output logic              perr,
  output logic              overrun,
  output logic              frag_err,
  input  logic              err_clr,
  output logic              busy
);

  localparam int unsigned NSYM  = WORD_W / 2;
  localparam int unsigned CNT_W = $clog2(NSYM + 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV
`ifdef SREG_RX_PARITY_EN
    , PAR
`endif
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [WORD_W-1:0]   sh;
  logic [WORD_W-1:0]   shifted_c;
  logic [WORD_W-1:0]   done_word_c;
  logic                start_c;
  logic                shift_c;
  logic                done_c;
  logic                load_c;
  logic                drop_c;
  logic                frag_c;

  // State register
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, symbol acceptance and word completion
  always_comb begin
    state_nxt = state;
    start_c   = sin_valid && frame_start;
    shift_c   = 1'b0;
    done_c    = 1'b0;
    shifted_c = {sin_data, sh[WORD_W-1:2]};
    case (state)
      IDLE: begin
        if (start_c) begin
          state_nxt = RECV;
          shift_c   = 1'b1;
        end
      end
      RECV: begin
        if (start_c) begin
          shift_c = 1'b1;
        end else if (sin_valid) begin
          shift_c = 1'b1;
          if (cnt == CNT_W'(NSYM - 1)) begin
`ifdef SREG_RX_PARITY_EN
            state_nxt = PAR;
`else
            state_nxt = IDLE;
            done_c    = 1'b1;
`endif
          end
        end
      end
`ifdef SREG_RX_PARITY_EN
      PAR: begin
        if (start_c) begin
          state_nxt = RECV;
          shift_c   = 1'b1;
        end else if (sin_valid) begin
          state_nxt = IDLE;
          done_c    = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SREG_RX_PARITY_EN
  // In PAR the word is already fully assembled in sh
  assign done_word_c = sh;
`else
  // The completing symbol is still on sin_data
  assign done_word_c = shifted_c;
`endif

  assign load_c = done_c && (!out_valid || out_ready);
  assign drop_c = done_c && out_valid && !out_ready;
  assign frag_c = start_c && (state != IDLE);

  // Shift register, symbol count, output register and sticky flags
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      sh        <= '0;
      cnt       <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      frag_err  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (shift_c) begin
        sh <= shifted_c;
      end
      if (start_c) begin
        cnt <= CNT_W'(1);
      end else if (shift_c) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (load_c) begin
        data_out  <= done_word_c;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Set events take priority over err_clr
      if (drop_c) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
      if (frag_c) begin
        frag_err <= 1'b1;
      end else if (err_clr) begin
        frag_err <= 1'b0;
      end

      busy <= (state_nxt != IDLE);
    end
  end

`ifdef SREG_RX_PARITY_EN
  // Odd parity: the data bits plus the parity bit must XOR to 1
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      perr <= 1'b0;
    end else if (load_c) begin
      perr <= ~(^sh ^ sin_data[0]);
    end
  end
`else
  assign perr = 1'b0;
`endif

endmodule
